// File: rtl/inst_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : inst_queue                                                    |
// | Brief    : Circular instruction queue between fetch and decode, with     |
// |            flush, NOP presentation when empty and sticky underflow flag. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module inst_queue #(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] NOP_WORD = 16'hF000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_valid,
  input  logic [WIDTH-1:0]           push_data,
  output logic                       push_ready,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           instruction,
  output logic                       inst_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       underflow_err
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = $clog2(DEPTH+1);
  localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;
  logic             r_underflow;

  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_count == '0);
  assign w_do_push = push_valid && push_ready;
  assign w_do_pop  = pop && !w_empty;

  // Ready is derived from held count only, so a same-cycle pop never frees a slot.
  assign push_ready    = (r_count < c_depth);
  assign inst_valid    = !w_empty;
  assign instruction   = w_empty ? NOP_WORD : r_mem[r_rd_ptr];
  assign count         = r_count;
  assign underflow_err = r_underflow;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      if (pop && w_empty) r_underflow <= 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides which entries are visible.
  always_ff @(posedge clk) begin
    if (reset_n && !flush && w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_inst_queue                                                 |
// | Brief    : Scoreboard bench for inst_queue against a queue-based model.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_inst_queue;

  localparam logic [15:0] c_nop = 16'hF000;

  typedef struct {
    logic [15:0] inst;
    logic        valid;
    int          cnt;
    logic        ready;
    logic        uf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        push_valid = 1'b0;
  logic [15:0] push_data = '0;
  logic        push_ready;
  logic        pop = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] instruction;
  logic        inst_valid;
  logic [2:0]  count;
  logic        underflow_err;

  int errors = 0;
  int checks = 0;

  logic [15:0] model_q[$];
  logic        model_uf = 1'b0;
  exp_t        exp_q[$];

  inst_queue #(.WIDTH(16), .DEPTH(4), .NOP_WORD(16'hF000)) dut (
    .clk(clk), .reset_n(reset_n), .push_valid(push_valid), .push_data(push_data),
    .push_ready(push_ready), .pop(pop), .flush(flush), .instruction(instruction),
    .inst_valid(inst_valid), .count(count), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and record what the queue must show afterwards.
  task automatic step(input logic rn, input logic pv, input logic [15:0] pd,
                      input logic p, input logic f);
    exp_t e;
    int n;
    logic acc;
    @(negedge clk);
    reset_n = rn; push_valid = pv; push_data = pd; pop = p; flush = f;
    if (!rn) begin
      model_q.delete();
      model_uf = 1'b0;
    end else if (f) begin
      model_q.delete();
    end else begin
      n = model_q.size();
      acc = pv && (n < 4);
      if (p) begin
        if (n != 0) void'(model_q.pop_front());
        else model_uf = 1'b1;
      end
      if (acc) model_q.push_back(pd);
    end
    e.cnt   = model_q.size();
    e.valid = (e.cnt != 0);
    e.inst  = e.valid ? model_q[0] : c_nop;
    e.ready = (e.cnt < 4);
    e.uf    = model_uf;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every registered update against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("instruction", 32'(instruction), 32'(e.inst));
      chk("inst_valid", 32'(inst_valid), 32'(e.valid));
      chk("count", 32'(count), 32'(e.cnt));
      chk("push_ready", 32'(push_ready), 32'(e.ready));
      chk("underflow_err", 32'(underflow_err), 32'(e.uf));
    end
  end

  initial begin
    // reset held with a push offered
    step(0, 1, 16'h9999, 0, 0);
    step(0, 1, 16'h9999, 0, 0);
    // fill, then overflow attempt
    step(1, 1, 16'h1111, 0, 0);
    step(1, 1, 16'h2222, 0, 0);
    step(1, 1, 16'h3333, 0, 0);
    step(1, 1, 16'h4444, 0, 0);
    step(1, 1, 16'h5555, 0, 0);
    // drain with pointer wrap
    step(1, 0, 16'h0, 1, 0);
    step(1, 0, 16'h0, 1, 0);
    step(1, 0, 16'h0, 1, 0);
    step(1, 1, 16'hAAAA, 0, 0);
    step(1, 1, 16'hBBBB, 0, 0);
    step(1, 0, 16'h0, 1, 0);
    // simultaneous push/pop at count 2
    step(1, 1, 16'hCCCC, 1, 0);
    // flush with push at count 3, then pop on empty
    step(1, 1, 16'hDDDD, 0, 0);
    step(1, 1, 16'hEEEE, 0, 1);
    step(1, 0, 16'h0, 1, 0);
    // underflow survives flush, push+pop while empty, then reset mid-operation
    step(1, 0, 16'h0, 0, 1);
    step(1, 1, 16'h1234, 1, 0);
    step(1, 1, 16'h5678, 0, 0);
    step(0, 1, 16'h4321, 1, 1);
    step(1, 0, 16'h0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
           16'($urandom), 1'($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0));
    end
    step(1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
